// File: rtl/cpu_mem_bridge.sv
// Boot-and-memory bridge: copies the program ROM into RAM after reset, then serves
// CPU read/write requests with fixed wait cycles and snoops writes on watch addresses.
module cpu_mem_bridge #(
    parameter int ADDR_BITS     = 16,
    parameter int DATA_BITS     = 16,
    parameter int RAM_ADDR_BITS = 9,
    parameter int ROM_ADDR_BITS = 8,
    parameter int READ_CYCLES   = 1,
    parameter int WRITE_CYCLES  = 2,
    parameter int NUM_WATCH     = 4
) (
    input  logic                           clock,
    input  logic                           rst,
    output logic [ROM_ADDR_BITS-1:0]       out_rom_addr,
    input  logic [DATA_BITS-1:0]           in_rom_data,
    output logic [RAM_ADDR_BITS-1:0]       out_ram_addr,
    output logic [DATA_BITS-1:0]           out_ram_data,
    output logic                           out_ram_write,
    input  logic [DATA_BITS-1:0]           in_ram_data,
    input  logic                           in_cpu_valid,
    input  logic                           in_cpu_write,
    input  logic [ADDR_BITS-1:0]           in_cpu_addr,
    input  logic [DATA_BITS-1:0]           in_cpu_data,
    output logic                           out_cpu_ready,
    output logic [DATA_BITS-1:0]           out_cpu_data,
    output logic                           out_cpu_run,
    output logic                           out_boot_done,
    input  logic [NUM_WATCH*ADDR_BITS-1:0] in_watch_addr,
    output logic [NUM_WATCH*DATA_BITS-1:0] out_watch_data,
    output logic [NUM_WATCH-1:0]           out_watch_hit
);

    localparam int MAX_WAIT = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_CYCLES);

    typedef enum logic [1:0] {TOP_RESET, TOP_COPY, TOP_RUN} top_state_t;
    typedef enum logic [1:0] {ACC_IDLE, ACC_READ, ACC_WRITE} acc_state_t;

    top_state_t                   top_state, top_next;
    acc_state_t                   acc_state, acc_next;
    logic [ROM_ADDR_BITS-1:0]     copy_cnt, copy_next;
    logic [CNT_W-1:0]             wait_cnt, wait_next;
    logic [NUM_WATCH*DATA_BITS-1:0] watch_data, watch_data_next;
    logic [NUM_WATCH-1:0]         watch_hit, watch_hit_next;
    logic                         start;
    logic [RAM_ADDR_BITS-1:0]     lat_addr;
    logic [DATA_BITS-1:0]         lat_data;

    always_ff @(posedge clock) begin
        if (rst) begin
            top_state  <= TOP_RESET;
            acc_state  <= ACC_IDLE;
            copy_cnt   <= '0;
            wait_cnt   <= '0;
            watch_data <= '0;
            watch_hit  <= '0;
        end else begin
            top_state  <= top_next;
            acc_state  <= acc_next;
            copy_cnt   <= copy_next;
            wait_cnt   <= wait_next;
            watch_data <= watch_data_next;
            watch_hit  <= watch_hit_next;
        end
    end

    // Request latch: only meaningful while a READ/WRITE is in flight, so no reset.
    always_ff @(posedge clock) begin
        if (start) begin
            lat_addr <= in_cpu_addr[RAM_ADDR_BITS-1:0];
            lat_data <= in_cpu_data;
        end
    end

    always_comb begin
        top_next        = top_state;
        acc_next        = acc_state;
        copy_next       = copy_cnt;
        wait_next       = wait_cnt;
        watch_data_next = watch_data;
        watch_hit_next  = '0;
        start           = 1'b0;
        out_rom_addr    = '0;
        out_ram_addr    = '0;
        out_ram_data    = '0;
        out_ram_write   = 1'b0;
        out_cpu_ready   = 1'b0;
        out_cpu_data    = '0;
        out_cpu_run     = 1'b0;
        out_boot_done   = 1'b0;

        case (top_state)
            TOP_RESET: begin
                top_next  = TOP_COPY;
                copy_next = '0;
            end
            TOP_COPY: begin
                out_rom_addr  = copy_cnt;
                out_ram_addr  = RAM_ADDR_BITS'(copy_cnt);
                out_ram_data  = in_rom_data;
                out_ram_write = 1'b1;
                copy_next     = copy_cnt + 1'b1;
                if (copy_cnt == {ROM_ADDR_BITS{1'b1}}) begin
                    top_next = TOP_RUN;
                end
            end
            TOP_RUN: begin
                out_cpu_run   = 1'b1;
                out_boot_done = 1'b1;
                case (acc_state)
                    ACC_IDLE: begin
                        // Present the address now so a zero-wait read finds valid RAM data.
                        out_ram_addr = in_cpu_addr[RAM_ADDR_BITS-1:0];
                        if (in_cpu_valid) begin
                            start     = 1'b1;
                            wait_next = '0;
                            acc_next  = in_cpu_write ? ACC_WRITE : ACC_READ;
                            if (in_cpu_write) begin
                                for (int i = 0; i < NUM_WATCH; i++) begin
                                    if (in_watch_addr[i*ADDR_BITS +: ADDR_BITS] == in_cpu_addr) begin
                                        watch_hit_next[i] = 1'b1;
                                        watch_data_next[i*DATA_BITS +: DATA_BITS] = in_cpu_data;
                                    end
                                end
                            end
                        end
                    end
                    ACC_READ: begin
                        out_ram_addr = lat_addr;
                        wait_next    = wait_cnt + 1'b1;
                        if (wait_cnt == READ_LAST) begin
                            out_cpu_ready = 1'b1;
                            out_cpu_data  = in_ram_data;
                            acc_next      = ACC_IDLE;
                        end
                    end
                    ACC_WRITE: begin
                        out_ram_addr  = lat_addr;
                        out_ram_data  = lat_data;
                        out_ram_write = 1'b1;
                        wait_next     = wait_cnt + 1'b1;
                        if (wait_cnt == WRITE_LAST) begin
                            out_cpu_ready = 1'b1;
                            acc_next      = ACC_IDLE;
                        end
                    end
                    default: acc_next = ACC_IDLE;
                endcase
            end
            default: top_next = TOP_RESET;
        endcase
    end

    assign out_watch_data = watch_data;
    assign out_watch_hit  = watch_hit;

endmodule
